// File: rtl/pwm_period_counter.sv
// PWM timebase: free-running sawtooth or triangle counter with a shadowed period
// and a load strobe that coincides with tick 0 of every period.
module pwm_period_counter #(
    parameter int bitwidth              = 10,
    parameter int enable_center_aligned = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [bitwidth-1:0] period,
    input  logic                force_restart,
    output logic [bitwidth-1:0] counter_value,
    output logic                load_enable,
    output logic                counting_down,
    output logic [bitwidth-1:0] active_period
);
    localparam logic [bitwidth-1:0] ONE = {{(bitwidth-1){1'b0}}, 1'b1};

    logic [bitwidth-1:0] counter_reg;
    logic [bitwidth-1:0] active_period_reg;
    logic                down_reg;
    logic                load_enable_reg;
    logic                pending_load_reg;

    logic                natural_wrap;
    logic [bitwidth-1:0] step_value;
    logic                step_down;
    logic                boundary;

    generate
        if (enable_center_aligned != 0) begin : g_center
            // A peak of 1 turns straight into the next period's 0, so it wraps
            // from the ascending side as well.
            always_comb begin
                natural_wrap = (active_period_reg == '0)
                            || ((counter_reg == ONE) && (down_reg || (active_period_reg == ONE)));
                step_value   = counter_reg + ONE;
                step_down    = down_reg;
                if (down_reg) begin
                    step_value = counter_reg - ONE;
                end else if (counter_reg == active_period_reg) begin
                    step_down  = 1'b1;
                    step_value = active_period_reg - ONE;
                end
            end
        end else begin : g_edge
            always_comb begin
                natural_wrap = (counter_reg == active_period_reg);
                step_value   = counter_reg + ONE;
                step_down    = 1'b0;
            end
        end
    endgenerate

    assign boundary = pending_load_reg || force_restart || natural_wrap;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter_reg       <= '0;
            active_period_reg <= '0;
            down_reg          <= 1'b0;
            load_enable_reg   <= 1'b0;
            pending_load_reg  <= 1'b1;
        end else if (enable) begin
            if (boundary) begin
                counter_reg       <= '0;
                active_period_reg <= period;
                down_reg          <= 1'b0;
                load_enable_reg   <= 1'b1;
                pending_load_reg  <= 1'b0;
            end else begin
                counter_reg     <= step_value;
                down_reg        <= step_down;
                load_enable_reg <= 1'b0;
            end
        end else begin
            load_enable_reg <= 1'b0;
        end
    end

    assign counter_value = counter_reg;
    assign load_enable   = load_enable_reg;
    assign counting_down = down_reg;
    assign active_period = active_period_reg;

endmodule

// File: tb/tb_pwm_period_counter.sv
// Randomised and directed bench for both counting modes of pwm_period_counter,
// checked against a position-within-period reference model.
module tb_pwm_period_counter;
    localparam int BW = 10;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [BW-1:0] period;
    logic          force_restart;

    logic [BW-1:0] e_cv, c_cv, e_ap, c_ap;
    logic          e_le, c_le, e_cd, c_cd;

    int errors = 0;
    int checks = 0;

    // Model: position inside the current period plus the period in use.
    int m_pos[2];
    int m_ap[2];
    bit m_pending[2];
    bit m_load[2];

    pwm_period_counter #(.bitwidth(BW), .enable_center_aligned(0)) dut_edge (
        .clock(clock), .reset(reset), .enable(enable), .period(period),
        .force_restart(force_restart), .counter_value(e_cv), .load_enable(e_le),
        .counting_down(e_cd), .active_period(e_ap)
    );

    pwm_period_counter #(.bitwidth(BW), .enable_center_aligned(1)) dut_center (
        .clock(clock), .reset(reset), .enable(enable), .period(period),
        .force_restart(force_restart), .counter_value(c_cv), .load_enable(c_le),
        .counting_down(c_cd), .active_period(c_ap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int period_len(input int m);
        if (m == 0) return m_ap[m] + 1;
        return (m_ap[m] == 0) ? 1 : 2 * m_ap[m];
    endfunction

    function automatic logic [2*BW+1:0] model_exp(input int m);
        logic [BW-1:0] v;
        logic [BW-1:0] a;
        logic          d;
        if (m == 0 || m_pos[m] <= m_ap[m]) v = BW'(m_pos[m]);
        else v = BW'(2 * m_ap[m] - m_pos[m]);
        d = (m == 1) && (m_pos[m] > m_ap[m]);
        a = BW'(m_ap[m]);
        return {v, m_load[m], d, a};
    endfunction

    function automatic logic [2*BW+1:0] obs_dut(input int m);
        if (m == 0) return {e_cv, e_le, e_cd, e_ap};
        return {c_cv, c_le, c_cd, c_ap};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pos[m] = 0; m_ap[m] = 0; m_pending[m] = 1'b1; m_load[m] = 1'b0;
        end
    endtask

    // Advance model and DUTs by one clock with the inputs currently applied.
    task automatic step();
        for (int m = 0; m < 2; m++) begin
            if (enable) begin
                if (m_pending[m] || force_restart || m_pos[m] == period_len(m) - 1) begin
                    m_pos[m] = 0; m_ap[m] = int'(period); m_pending[m] = 1'b0; m_load[m] = 1'b1;
                end else begin
                    m_pos[m] = m_pos[m] + 1; m_load[m] = 1'b0;
                end
            end else begin
                m_load[m] = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        $display("t=%0t en=%0b per=%0d fr=%0b | edge cv=%0d le=%0b ap=%0d | center cv=%0d le=%0b cd=%0b ap=%0d",
                 $time, enable, period, force_restart, e_cv, e_le, e_ap, c_cv, c_le, c_cd, c_ap);
    endtask

    task automatic wait_edge_value(input int target, input string tag);
        logic [BW-1:0] tgt;
        int n;
        tgt = BW'(target);
        n = 0;
        while (e_cv !== tgt && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (e_cv !== tgt) begin
            errors++;
            $display("FAIL %s timeout: counter_value=%0d never reached %0d", tag, e_cv, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; period = 10'd4; force_restart = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL reset[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_sawtooth();
        period = 10'd4;
        for (int i = 0; i < 12; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL sawtooth[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
    endtask

    task automatic test_center();
        period = 10'd3;
        for (int i = 0; i < 16; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL center[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
        period = 10'd1;
        for (int i = 0; i < 10; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL center_p1[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
    endtask

    task automatic test_period_change();
        period = 10'd4;
        wait_edge_value(0, "period_change_sync");
        wait_edge_value(2, "period_change");
        period = 10'd7;
        for (int i = 0; i < 20; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL period_change[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        wait_edge_value(3, "enable_hold");
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) enable = 1'b1;
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL enable_hold[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
    endtask

    task automatic test_force_restart();
        period = 10'd9;
        wait_edge_value(2, "force_restart");
        for (int i = 0; i < 4; i++) begin
            force_restart = (i == 0);
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL force_restart[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
        force_restart = 1'b0;
        wait_edge_value(9, "force_at_wrap");
        for (int i = 0; i < 4; i++) begin
            force_restart = (i == 0);
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL force_at_wrap[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
        // A restart request while disabled must be forgotten.
        for (int i = 0; i < 5; i++) begin
            enable        = (i >= 2);
            force_restart = (i == 1);
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL force_disabled[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
        force_restart = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_period_zero();
        period = 10'd0;
        for (int i = 0; i < 30; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL period_zero[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        period = 10'd5;
        wait_edge_value(3, "reset_mid");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_dut(m) !== model_exp(m)) begin
                errors++;
                $display("FAIL reset_async mode=%0d got=%h expected=%h", m, obs_dut(m), model_exp(m));
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL reset_release[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) period = BW'($urandom_range(0, 12));
            enable        = ($urandom_range(0, 9) != 0);
            force_restart = ($urandom_range(0, 24) == 0);
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs_dut(m) !== model_exp(m)) begin
                    errors++;
                    $display("FAIL random[%0d] mode=%0d got=%h expected=%h", i, m, obs_dut(m), model_exp(m));
                end
            end
        end
        force_restart = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; period = '0; force_restart = 1'b0;
        model_reset();
        test_reset();
        test_sawtooth();
        test_center();
        test_period_change();
        test_enable_hold();
        test_force_restart();
        test_period_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_period_counter.md
Name: pwm_period_counter

Overview:
Free-running timebase for the PWM blocks. It generates counter_value and a one-cycle load_enable strobe at every period boundary. Its outputs feed the pulse generators directly: they compare counter_value against their edge tick numbers and reload their double-buffered thresholds on load_enable. Supports edge-aligned (sawtooth) and center-aligned (triangle) counting, a double-buffered period, and a forced restart.

Parameters:
bitwidth, 10, width of counter_value and period
enable_center_aligned, 0, 0 = sawtooth 0..top then wrap; 1 = triangle 0..top..1 then 0

Ports:
clock  input  1  single clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset)
enable  input  1  1 = counter advances each clock; 0 = all state held
period  input  bitwidth  requested top value; sampled only at a period boundary
force_restart  input  1  synchronous; starts a new period on the next enabled edge
counter_value  output  bitwidth  current tick number (registered)
load_enable  output  1  high for exactly the cycle in which counter_value is the first tick (0) of a period
counting_down  output  1  center-aligned only: 1 while descending; tied 0 when enable_center_aligned = 0
active_period  output  bitwidth  top value in use for the current period (shadow register)

Behaviour:
- Reset asserted (reset = 0), asynchronous: counter_value = 0, load_enable = 0, counting_down = 0, active_period = 0, internal pending_load = 1.
- Every output is registered; no combinational path from any input to any output.
- enable = 0: counter_value, counting_down, active_period and pending_load hold. load_enable = 0.
- Boundary edge: any enabled edge on which one of the following holds:
  - pending_load = 1, or force_restart = 1, or
  - edge mode: counter_value == active_period, or
  - center mode: counting_down = 1 and counter_value == 1, or
  - center mode: active_period == 0.
- On a boundary edge: counter_value <= 0, load_enable <= 1, active_period <= period, counting_down <= 0, pending_load <= 0.
- Consequence: load_enable and the first tick 0 appear in the same cycle, so downstream blocks compare against newly loaded thresholds in that cycle.
- Edge mode, non-boundary enabled edge: counter_value <= counter_value + 1, load_enable <= 0.
- Edge mode period length = active_period + 1 cycles.
- Center mode, non-boundary enabled edge, ascending:
  - if counter_value == active_period: counting_down <= 1 and counter_value <= active_period - 1;
  - otherwise counter_value increments.
- Center mode, descending, non-boundary: counter_value decrements.
- Center mode period length = 2 * active_period cycles.
  - active_period == 1 gives the sequence 0,1,0,1 with load_enable on every 0.
  - The peak is at active_period; 0 occurs once per period.
- active_period == 0, either mode: counter_value stays 0 and load_enable = 1 on every enabled edge.
- A change on period mid-period has no effect until the next boundary edge. The period value sampled is the one present at that edge.
- force_restart together with a natural boundary: a single boundary edge, no extra cycle.
- force_restart while enable = 0: ignored. It is not latched.
- Reset asserted mid-period: immediate return to the reset state.
  - After release, the first enabled edge is a boundary edge (pending_load), so counter_value reads 0 for the reset cycle(s) and again with load_enable = 1.
- Arithmetic: unsigned modulo 2^bitwidth. The counter never exceeds active_period, so no overflow is reachable.

Decomposition:
- No shared package. The mode is selected by the enable_center_aligned parameter through a generate branch.
- No sub-module. The period shadow register stays local because it needs the asynchronous active-low reset.
- The block is instanced next to one or more pulse generators sharing counter_value and load_enable.

Test Plan:
1. Edge mode: reset low 3 cycles, release, enable = 1, period = 4 -> counter_value 0(load),1,2,3,4,0(load),1...; load_enable every 5th cycle.
2. Center mode, period = 3 -> counter_value 0(load),1,2,3,2,1,0(load); counting_down high on the ticks 2,1 after the peak; 6-cycle period.
3. Period change 4 -> 7 while counter_value = 2 -> count continues to 4, wraps with load_enable, active_period = 7, next period 8 cycles.
4. enable low for 5 cycles at counter_value = 3 -> value held at 3, load_enable 0 throughout, resumes at 4.
5. force_restart at counter_value = 2, period = 9 -> next cycle counter_value 0, load_enable 1, active_period 9; force_restart coincident with a natural wrap gives a single load_enable.
6. period = 0 (both modes) -> counter_value constant 0, load_enable 1 every enabled cycle; reset pulse mid-count (counter_value = 3) -> outputs 0 asynchronously, first enabled edge after release asserts load_enable.
